// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame/register geometry.
package uart_pkg;

  localparam int unsigned OVS       = 16;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned REG_W     = 32;
  localparam int unsigned OVS_W     = $clog2(OVS);
  localparam int unsigned IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module baud_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("baud_tick_gen: DIV must be at least 1");
  end

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with 16x oversampling; delivers each byte as a
// zero-extended write strobe into the data register.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned BAUD        = 9600
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             rx_i,
  output logic [REG_W-1:0] data_o,
  output logic             we_o,
  output logic             busy_o,
  output logic             frame_err_o
);

  localparam int unsigned DIV = CLK_FREQ_HZ / (BAUD * OVS);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_ctrl: CLK_FREQ_HZ / (BAUD*16) must be at least 1");
  end

  logic tick_c;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_c  (tick_c)
  );

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  logic fall_c;
  assign fall_c = rx_prev & ~rx_s2;

  rx_state_t            state, state_d;
  logic [OVS_W-1:0]     tick_cnt, tick_cnt_d;
  logic [IDX_W-1:0]     bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [REG_W-1:0]     data_d;
  logic                 we_d, ferr_d;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_o      <= '0;
      we_o        <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_d;
      tick_cnt    <= tick_cnt_d;
      bit_idx     <= bit_idx_d;
      shift       <= shift_d;
      data_o      <= data_d;
      we_o        <= we_d;
      frame_err_o <= ferr_d;
      busy_o      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    data_d     = data_o;
    we_d       = 1'b0;
    ferr_d     = 1'b0;

    unique case (state)
      IDLE: begin
        if (fall_c) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick_c) begin
          if (tick_cnt == OVS_W'(OVS / 2 - 1)) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rx_s2 ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt + OVS_W'(1);
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          if (tick_cnt == OVS_W'(OVS - 1)) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s2, shift[DATA_BITS-1:1]};
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx + IDX_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt + OVS_W'(1);
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          if (tick_cnt == OVS_W'(OVS - 1)) begin
            tick_cnt_d = '0;
            if (rx_s2) begin
              data_d = REG_W'(shift);
              we_d   = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            // An edge coinciding with the exit must start the next frame.
            state_d = fall_c ? START : IDLE;
          end else begin
            tick_cnt_d = tick_cnt + OVS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit (one tick per clock).
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        rx_i = 1'b1;
  logic [31:0] data_o;
  logic        we_o;
  logic        busy_o;
  logic        frame_err_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned cyc = 0;
  int unsigned we_cnt = 0;
  int unsigned ferr_cnt = 0;
  int unsigned busy_cnt = 0;
  int unsigned both_cnt = 0;
  int unsigned we_cyc = 0;
  int unsigned start_cyc = 0;
  logic [31:0] we_q[$];

  uart_rx_ctrl #(
    .CLK_FREQ_HZ (16_000_000),
    .BAUD        (1_000_000)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .we_o        (we_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_o) begin
      we_cnt++;
      we_cyc = cyc;
      we_q.push_back(data_o);
    end
    if (frame_err_o) ferr_cnt++;
    if (busy_o) busy_cnt++;
    if (we_o && frame_err_o) both_cnt++;
  end

  // Caller is aligned to a falling clock edge; returns aligned likewise.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    start_cyc = cyc;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (16) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (16) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic clear_counts();
    we_cnt = 0;
    ferr_cnt = 0;
    busy_cnt = 0;
    we_q.delete();
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (data_o !== 32'h0 || we_o !== 1'b0 || busy_o !== 1'b0 || frame_err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: data=%h we=%b busy=%b ferr=%b want 0/0/0/0",
               data_o, we_o, busy_o, frame_err_o);
    end
    reset_i = 1'b1;
    clear_counts();
    repeat (500) @(negedge clk);
    total++;
    if (we_cnt !== 0) begin
      bad++;
      $display("FAIL idle_we: got %0d pulses want 0", we_cnt);
    end
    total++;
    if (busy_cnt !== 0) begin
      bad++;
      $display("FAIL idle_busy: busy high %0d cycles want 0", busy_cnt);
    end
    total++;
    if (data_o !== 32'h0) begin
      bad++;
      $display("FAIL idle_data: got %h want 00000000", data_o);
    end
  endtask

  task automatic test_single_frame();
    clear_counts();
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    total++;
    if (we_cnt !== 1) begin
      bad++;
      $display("FAIL a5_we_count: got %0d want 1", we_cnt);
    end
    total++;
    if (data_o !== 32'h0000_00A5) begin
      bad++;
      $display("FAIL a5_data: got %h want 000000a5", data_o);
    end
    total++;
    if (we_cyc - start_cyc !== 155) begin
      bad++;
      $display("FAIL a5_latency: got %0d want 155", we_cyc - start_cyc);
    end
    total++;
    if (ferr_cnt !== 0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL a5_ferr_busy: ferr=%0d busy=%b want 0/0", ferr_cnt, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    clear_counts();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    d0 = (we_q.size() > 0) ? we_q[0] : 32'hDEAD_BEEF;
    d1 = (we_q.size() > 1) ? we_q[1] : 32'hDEAD_BEEF;
    total++;
    if (we_cnt !== 2) begin
      bad++;
      $display("FAIL b2b_we_count: got %0d want 2", we_cnt);
    end
    total++;
    if (d0 !== 32'h0000_003C) begin
      bad++;
      $display("FAIL b2b_first: got %h want 0000003c", d0);
    end
    total++;
    if (d1 !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL b2b_second: got %h want 000000ff", d1);
    end
  endtask

  task automatic test_frame_error();
    clear_counts();
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    total++;
    if (ferr_cnt !== 1) begin
      bad++;
      $display("FAIL ferr_count: got %0d want 1", ferr_cnt);
    end
    total++;
    if (we_cnt !== 0) begin
      bad++;
      $display("FAIL ferr_we: got %0d want 0", we_cnt);
    end
    total++;
    if (data_o !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL ferr_data_hold: got %h want 000000ff", data_o);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    total++;
    if (we_cnt !== 0 || ferr_cnt !== 0) begin
      bad++;
      $display("FAIL glitch_strobe: we=%0d ferr=%0d want 0/0", we_cnt, ferr_cnt);
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy: got %b want 0", busy_o);
    end
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    total++;
    if (we_cnt !== 1 || data_o !== 32'h0000_0081) begin
      bad++;
      $display("FAIL glitch_next_frame: we=%0d data=%h want 1/00000081", we_cnt, data_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h7E;
    clear_counts();
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_i = b[i];
      repeat (16) @(negedge clk);
    end
    rx_i = b[3];
    repeat (8) @(negedge clk);
    reset_i = 1'b0;
    #1;
    total++;
    if (data_o !== 32'h0 || we_o !== 1'b0 || busy_o !== 1'b0 || frame_err_o !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: data=%h we=%b busy=%b ferr=%b want 0/0/0/0",
               data_o, we_o, busy_o, frame_err_o);
    end
    @(negedge clk);
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    repeat (200) @(negedge clk);
    total++;
    if (we_cnt !== 0 || ferr_cnt !== 0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet: we=%0d ferr=%0d busy=%b want 0/0/0", we_cnt, ferr_cnt, busy_o);
    end
    send_frame(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    total++;
    if (we_cnt !== 1 || data_o !== 32'h0000_0012) begin
      bad++;
      $display("FAIL midreset_next_frame: we=%0d data=%h want 1/00000012", we_cnt, data_o);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    total++;
    if (both_cnt !== 0) begin
      bad++;
      $display("FAIL we_ferr_overlap: got %0d cycles want 0", both_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
